// File: rtl/snitch_dma_event_monitor.sv
// Passive event monitor for the cluster DMA AXI port and data buffer; produces registered perf-counter events.
// Optional build macro SNITCH_DMA_EVENT_BYTE_ACCURATE_EN: exact per-beat byte count from W strobes.
module snitch_dma_event_monitor #(
    parameter int unsigned DataWidth      = 512,
    parameter int unsigned MaxOutstanding = 16,
    parameter int unsigned StrbWidth      = DataWidth / 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         aw_valid_i,
    input  logic                         aw_ready_i,
    input  logic [7:0]                   aw_len_i,
    input  logic [2:0]                   aw_size_i,
    input  logic                         ar_valid_i,
    input  logic                         ar_ready_i,
    input  logic [7:0]                   ar_len_i,
    input  logic [2:0]                   ar_size_i,
    input  logic                         w_valid_i,
    input  logic                         w_ready_i,
    input  logic [StrbWidth-1:0]         w_strb_i,
    input  logic                         r_valid_i,
    input  logic                         r_ready_i,
    input  logic                         r_last_i,
    input  logic                         b_valid_i,
    input  logic                         b_ready_i,
    input  logic                         buf_w_valid_i,
    input  logic                         buf_w_ready_i,
    input  logic                         buf_r_valid_i,
    input  logic                         buf_r_ready_i,
    output logic                         aw_stall_o,
    output logic                         ar_stall_o,
    output logic                         r_stall_o,
    output logic                         w_stall_o,
    output logic                         buf_w_stall_o,
    output logic                         buf_r_stall_o,
    output logic                         aw_done_o,
    output logic                         ar_done_o,
    output logic                         r_done_o,
    output logic                         w_done_o,
    output logic                         b_done_o,
    output logic [7:0]                   aw_len_o,
    output logic [7:0]                   ar_len_o,
    output logic [2:0]                   aw_size_o,
    output logic [2:0]                   ar_size_o,
    output logic [$clog2(StrbWidth):0]   num_bytes_written_o,
    output logic                         dma_busy_o,
    output logic                         error_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned NbW  = $clog2(StrbWidth) + 1;

    logic aw_hs, ar_hs, w_hs, r_hs, b_hs;
    logic wr_inc, wr_dec, rd_inc, rd_dec;

    logic [5:0]      stall_d, stall_q;
    logic [4:0]      done_d, done_q;
    logic [7:0]      aw_len_d, aw_len_q, ar_len_d, ar_len_q;
    logic [2:0]      aw_size_d, aw_size_q, ar_size_d, ar_size_q;
    logic [NbW-1:0]  nbytes_d, nbytes_q;
    logic [CntW-1:0] wr_cnt_d, wr_cnt_q, rd_cnt_d, rd_cnt_q;
    logic            busy_d, busy_q;
    logic            error_d, error_q;
    logic [NbW-1:0]  strb_popcnt;

    assign aw_hs = aw_valid_i & aw_ready_i;
    assign ar_hs = ar_valid_i & ar_ready_i;
    assign w_hs  = w_valid_i & w_ready_i;
    assign r_hs  = r_valid_i & r_ready_i;
    assign b_hs  = b_valid_i & b_ready_i;

    assign wr_inc = aw_hs;
    assign wr_dec = b_hs;
    assign rd_inc = ar_hs;
    assign rd_dec = r_hs & r_last_i;

`ifdef SNITCH_DMA_EVENT_BYTE_ACCURATE_EN
    always_comb begin
        strb_popcnt = '0;
        for (int i = 0; i < StrbWidth; i++) begin
            strb_popcnt = strb_popcnt + NbW'(w_strb_i[i]);
        end
    end
`else
    // Every W beat is counted as a full-width beat; strobes are not inspected.
    logic unused_strb;
    assign unused_strb = ^w_strb_i;
    assign strb_popcnt = NbW'(StrbWidth);
`endif

    always_comb begin
        stall_d   = {aw_valid_i & ~aw_ready_i, ar_valid_i & ~ar_ready_i,
                     r_valid_i & ~r_ready_i, w_valid_i & ~w_ready_i,
                     buf_w_valid_i & ~buf_w_ready_i, buf_r_valid_i & ~buf_r_ready_i};
        done_d    = {aw_hs, ar_hs, r_hs, w_hs, b_hs};
        aw_len_d  = aw_hs ? aw_len_i : 8'd0;
        aw_size_d = aw_hs ? aw_size_i : 3'd0;
        ar_len_d  = ar_hs ? ar_len_i : 8'd0;
        ar_size_d = ar_hs ? ar_size_i : 3'd0;
        nbytes_d  = w_hs ? strb_popcnt : '0;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        error_d   = error_q;

        // Simultaneous increment and decrement cancel out.
        if (wr_inc && !wr_dec) begin
            if (wr_cnt_q == CntW'(MaxOutstanding)) error_d = 1'b1;
            else                                   wr_cnt_d = wr_cnt_q + 1'b1;
        end else if (wr_dec && !wr_inc) begin
            if (wr_cnt_q == '0) error_d = 1'b1;
            else                wr_cnt_d = wr_cnt_q - 1'b1;
        end

        if (rd_inc && !rd_dec) begin
            if (rd_cnt_q == CntW'(MaxOutstanding)) error_d = 1'b1;
            else                                   rd_cnt_d = rd_cnt_q + 1'b1;
        end else if (rd_dec && !rd_inc) begin
            if (rd_cnt_q == '0) error_d = 1'b1;
            else                rd_cnt_d = rd_cnt_q - 1'b1;
        end

        busy_d = (wr_cnt_d != '0) | (rd_cnt_d != '0) | aw_valid_i | ar_valid_i | w_valid_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q   <= '0;
            done_q    <= '0;
            aw_len_q  <= '0;
            aw_size_q <= '0;
            ar_len_q  <= '0;
            ar_size_q <= '0;
            nbytes_q  <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            done_q    <= done_d;
            aw_len_q  <= aw_len_d;
            aw_size_q <= aw_size_d;
            ar_len_q  <= ar_len_d;
            ar_size_q <= ar_size_d;
            nbytes_q  <= nbytes_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
        end
    end

    assign {aw_stall_o, ar_stall_o, r_stall_o, w_stall_o, buf_w_stall_o, buf_r_stall_o} = stall_q;
    assign {aw_done_o, ar_done_o, r_done_o, w_done_o, b_done_o} = done_q;
    assign aw_len_o            = aw_len_q;
    assign aw_size_o           = aw_size_q;
    assign ar_len_o            = ar_len_q;
    assign ar_size_o           = ar_size_q;
    assign num_bytes_written_o = nbytes_q;
    assign dma_busy_o          = busy_q;
    assign error_o             = error_q;

endmodule

// File: tb/tb_snitch_dma_event_monitor.sv
// Directed bench for snitch_dma_event_monitor: expected events queued at drive time, checked one cycle later.
module tb_snitch_dma_event_monitor;

    localparam int DW  = 512;
    localparam int SW  = DW / 8;
    localparam int MO  = 16;
    localparam int NBW = $clog2(SW) + 1;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          aw_valid_i = 0, aw_ready_i = 0, ar_valid_i = 0, ar_ready_i = 0;
    logic [7:0]    aw_len_i = 0, ar_len_i = 0;
    logic [2:0]    aw_size_i = 0, ar_size_i = 0;
    logic          w_valid_i = 0, w_ready_i = 0;
    logic [SW-1:0] w_strb_i = '0;
    logic          r_valid_i = 0, r_ready_i = 0, r_last_i = 0, b_valid_i = 0, b_ready_i = 0;
    logic          buf_w_valid_i = 0, buf_w_ready_i = 0, buf_r_valid_i = 0, buf_r_ready_i = 0;

    logic           aw_stall_o, ar_stall_o, r_stall_o, w_stall_o, buf_w_stall_o, buf_r_stall_o;
    logic           aw_done_o, ar_done_o, r_done_o, w_done_o, b_done_o;
    logic [7:0]     aw_len_o, ar_len_o;
    logic [2:0]     aw_size_o, ar_size_o;
    logic [NBW-1:0] num_bytes_written_o;
    logic           dma_busy_o, error_o;

    snitch_dma_event_monitor #(.DataWidth(DW), .MaxOutstanding(MO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .aw_valid_i(aw_valid_i), .aw_ready_i(aw_ready_i), .aw_len_i(aw_len_i), .aw_size_i(aw_size_i),
        .ar_valid_i(ar_valid_i), .ar_ready_i(ar_ready_i), .ar_len_i(ar_len_i), .ar_size_i(ar_size_i),
        .w_valid_i(w_valid_i), .w_ready_i(w_ready_i), .w_strb_i(w_strb_i),
        .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
        .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
        .buf_w_valid_i(buf_w_valid_i), .buf_w_ready_i(buf_w_ready_i),
        .buf_r_valid_i(buf_r_valid_i), .buf_r_ready_i(buf_r_ready_i),
        .aw_stall_o(aw_stall_o), .ar_stall_o(ar_stall_o), .r_stall_o(r_stall_o), .w_stall_o(w_stall_o),
        .buf_w_stall_o(buf_w_stall_o), .buf_r_stall_o(buf_r_stall_o),
        .aw_done_o(aw_done_o), .ar_done_o(ar_done_o), .r_done_o(r_done_o), .w_done_o(w_done_o),
        .b_done_o(b_done_o),
        .aw_len_o(aw_len_o), .ar_len_o(ar_len_o), .aw_size_o(aw_size_o), .ar_size_o(ar_size_o),
        .num_bytes_written_o(num_bytes_written_o), .dma_busy_o(dma_busy_o), .error_o(error_o)
    );

    typedef struct packed {
        logic [5:0]     stall;
        logic [4:0]     done;
        logic [7:0]     aw_len;
        logic [2:0]     aw_size;
        logic [7:0]     ar_len;
        logic [2:0]     ar_size;
        logic [NBW-1:0] nbytes;
        logic           busy;
        logic           err;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   m_wr     = 0;
    int   m_rd     = 0;
    logic m_err    = 1'b0;

    function automatic exp_t observe();
        exp_t o;
        o.stall   = {aw_stall_o, ar_stall_o, r_stall_o, w_stall_o, buf_w_stall_o, buf_r_stall_o};
        o.done    = {aw_done_o, ar_done_o, r_done_o, w_done_o, b_done_o};
        o.aw_len  = aw_len_o;
        o.aw_size = aw_size_o;
        o.ar_len  = ar_len_o;
        o.ar_size = ar_size_o;
        o.nbytes  = num_bytes_written_o;
        o.busy    = dma_busy_o;
        o.err     = error_o;
        return o;
    endfunction

    task automatic check(input string tag);
        exp_t e, o;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        o = observe();
        n_assert++;
        assert ({o.stall, o.done} === {e.stall, e.done}) else begin
            n_fail++;
            $error("FAIL %s events: got stall=%b done=%b, want stall=%b done=%b", tag, o.stall, o.done, e.stall, e.done);
        end
        n_assert++;
        assert ({o.aw_len, o.aw_size, o.ar_len, o.ar_size, o.nbytes} === {e.aw_len, e.aw_size, e.ar_len, e.ar_size, e.nbytes}) else begin
            n_fail++;
            $error("FAIL %s fields: got aw=%0d/%0d ar=%0d/%0d bytes=%0d, want aw=%0d/%0d ar=%0d/%0d bytes=%0d",
                   tag, o.aw_len, o.aw_size, o.ar_len, o.ar_size, o.nbytes, e.aw_len, e.aw_size, e.ar_len, e.ar_size, e.nbytes);
        end
        n_assert++;
        assert ({o.busy, o.err} === {e.busy, e.err}) else begin
            n_fail++;
            $error("FAIL %s status: got busy=%b err=%b, want busy=%b err=%b", tag, o.busy, o.err, e.busy, e.err);
        end
    endtask

    // Reference model: compute the expected registered outputs for the inputs currently driven.
    task automatic tick(input string tag);
        exp_t e;
        logic awh, arh, wh, rh, bh;
        e   = '0;
        awh = aw_valid_i & aw_ready_i;
        arh = ar_valid_i & ar_ready_i;
        wh  = w_valid_i & w_ready_i;
        rh  = r_valid_i & r_ready_i;
        bh  = b_valid_i & b_ready_i;
        e.stall = {aw_valid_i & ~aw_ready_i, ar_valid_i & ~ar_ready_i, r_valid_i & ~r_ready_i,
                   w_valid_i & ~w_ready_i, buf_w_valid_i & ~buf_w_ready_i, buf_r_valid_i & ~buf_r_ready_i};
        e.done  = {awh, arh, rh, wh, bh};
        if (awh) begin e.aw_len = aw_len_i; e.aw_size = aw_size_i; end
        if (arh) begin e.ar_len = ar_len_i; e.ar_size = ar_size_i; end
        if (wh) begin
`ifdef SNITCH_DMA_EVENT_BYTE_ACCURATE_EN
            e.nbytes = NBW'($countones(w_strb_i));
`else
            e.nbytes = NBW'(SW);
`endif
        end
        if (awh && !bh) begin
            if (m_wr == MO) m_err = 1'b1; else m_wr++;
        end else if (bh && !awh) begin
            if (m_wr == 0) m_err = 1'b1; else m_wr--;
        end
        if (arh && !(rh && r_last_i)) begin
            if (m_rd == MO) m_err = 1'b1; else m_rd++;
        end else if ((rh && r_last_i) && !arh) begin
            if (m_rd == 0) m_err = 1'b1; else m_rd--;
        end
        e.busy = (m_wr != 0) || (m_rd != 0) || aw_valid_i || ar_valid_i || w_valid_i;
        e.err  = m_err;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        check(tag);
    endtask

    task automatic idle_inputs();
        aw_valid_i = 0; aw_ready_i = 0; aw_len_i = 0; aw_size_i = 0;
        ar_valid_i = 0; ar_ready_i = 0; ar_len_i = 0; ar_size_i = 0;
        w_valid_i = 0; w_ready_i = 0; w_strb_i = '0;
        r_valid_i = 0; r_ready_i = 0; r_last_i = 0; b_valid_i = 0; b_ready_i = 0;
        buf_w_valid_i = 0; buf_w_ready_i = 0; buf_r_valid_i = 0; buf_r_ready_i = 0;
    endtask

    // Assert reset between clock edges; outputs must clear without waiting for a clock.
    task automatic pulse_reset(input string tag);
        exp_t o;
        #1 rst_ni = 1'b0;
        #1;
        o = observe();
        n_assert++;
        assert (o === exp_t'(0)) else begin
            n_fail++;
            $error("FAIL %s: got %h, want 0", tag, o);
        end
        m_wr = 0; m_rd = 0; m_err = 1'b0;
        exp_q.delete();
        #1 rst_ni = 1'b1;
    endtask

    initial begin
        exp_t o;
        idle_inputs();
        repeat (2) @(posedge clk_i);
        #1;
        o = observe();
        n_assert++;
        assert (o === exp_t'(0)) else begin
            n_fail++;
            $error("FAIL reset_state: got %h, want 0", o);
        end
        #2 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        tick("idle");

        // AW stalled 3 cycles, then handshake len=7 size=6
        aw_valid_i = 1; aw_len_i = 8'd7; aw_size_i = 3'd6;
        for (int i = 0; i < 3; i++) tick("aw_stall");
        aw_ready_i = 1; tick("aw_done");
        aw_valid_i = 0; aw_ready_i = 0; aw_len_i = 0; aw_size_i = 0;
        tick("aw_wait");

        // W beats: partial strobe, full strobe, one stalled beat
        w_valid_i = 1; w_ready_i = 1; w_strb_i = SW'(16'h00FF); tick("w_partial");
        w_strb_i = '1; tick("w_full");
        w_ready_i = 0; tick("w_stall");
        w_valid_i = 0; w_strb_i = '0; tick("w_wait");
        b_valid_i = 1; b_ready_i = 1; tick("b_done");
        b_valid_i = 0; b_ready_i = 0; tick("write_idle");

        // AR len=3 then 4 R beats with a stall before the last
        ar_valid_i = 1; ar_ready_i = 1; ar_len_i = 8'd3; ar_size_i = 3'd5; tick("ar_done");
        ar_valid_i = 0; ar_ready_i = 0; ar_len_i = 0; ar_size_i = 0;
        r_valid_i = 1; r_ready_i = 1;
        for (int i = 0; i < 3; i++) tick("r_beat");
        r_ready_i = 0; r_last_i = 1; tick("r_stall");
        r_ready_i = 1; tick("r_last");
        r_valid_i = 0; r_ready_i = 0; r_last_i = 0; tick("read_idle");
        tick("read_idle2");

        // Same-cycle AW and B with one write outstanding
        aw_valid_i = 1; aw_ready_i = 1; aw_len_i = 8'd1; aw_size_i = 3'd3; tick("aw_one");
        b_valid_i = 1; b_ready_i = 1; aw_len_i = 8'd2; tick("aw_b_same");
        aw_valid_i = 0; aw_ready_i = 0; aw_len_i = 0; aw_size_i = 0; tick("b_last");
        b_valid_i = 0; b_ready_i = 0; tick("same_idle");

        // Buffer stalls and a buffer handshake
        buf_w_valid_i = 1; buf_r_valid_i = 1; tick("buf_stall");
        buf_w_ready_i = 1; tick("buf_w_go");
        buf_r_ready_i = 1; tick("buf_both_go");
        buf_w_valid_i = 0; buf_r_valid_i = 0; buf_w_ready_i = 0; buf_r_ready_i = 0;

        // Overflow: 17 AW handshakes with no B
        aw_valid_i = 1; aw_ready_i = 1; aw_len_i = 8'hFF; aw_size_i = 3'd6;
        for (int i = 0; i < 17; i++) tick("aw_ovf");
        idle_inputs();
        tick("err_sticky");
        tick("err_sticky2");

        // Underflow after reset: B with count 0
        pulse_reset("reset_after_ovf");
        @(posedge clk_i); #1;
        tick("post_reset_idle");
        b_valid_i = 1; b_ready_i = 1; tick("b_underflow");
        idle_inputs(); tick("unf_sticky");

        // Reset mid-burst with two reads outstanding, then R-last underflow
        pulse_reset("reset_clear");
        @(posedge clk_i); #1;
        ar_valid_i = 1; ar_ready_i = 1; ar_len_i = 8'd15; ar_size_i = 3'd6;
        tick("ar_1");
        tick("ar_2");
        idle_inputs(); tick("two_reads");
        pulse_reset("reset_mid_burst");
        @(posedge clk_i); #1;
        tick("busy_after_reset");
        r_valid_i = 1; r_ready_i = 1; r_last_i = 1; tick("r_underflow");
        idle_inputs(); tick("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/snitch_dma_event_monitor.md
Name: snitch_dma_event_monitor

Overview:
- Passive monitor on the cluster DMA's AXI master port and its internal data buffer.
- Produces the per-cycle DMA event vector consumed by the cluster peripheral's performance counters: stall, done, burst length/size, bytes written and busy.
- Tracks outstanding read and write bursts to derive busy.
- Never drives AXI handshakes. All outputs are registered.

Parameters:
- DataWidth, 512, AXI data width in bits; must be a power of two, at least 64.
- MaxOutstanding, 16, maximum outstanding bursts per direction; sets counter width $clog2(MaxOutstanding+1).
- StrbWidth, DataWidth/8, derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- aw_valid_i, aw_ready_i  in  1 each  AXI AW handshake
- aw_len_i  in  8  AW burst length (beats-1)
- aw_size_i  in  3  AW beat size (log2 bytes)
- ar_valid_i, ar_ready_i  in  1 each  AXI AR handshake
- ar_len_i  in  8  AR burst length
- ar_size_i  in  3  AR beat size
- w_valid_i, w_ready_i  in  1 each  AXI W handshake
- w_strb_i  in  StrbWidth  W strobes
- r_valid_i, r_ready_i, r_last_i  in  1 each  AXI R handshake and last flag
- b_valid_i, b_ready_i  in  1 each  AXI B handshake
- buf_w_valid_i, buf_w_ready_i  in  1 each  buffer write side (R data into buffer)
- buf_r_valid_i, buf_r_ready_i  in  1 each  buffer read side (buffer out to W)
- aw_stall_o, ar_stall_o, r_stall_o, w_stall_o, buf_w_stall_o, buf_r_stall_o  out  1 each  channel valid and not ready
- aw_done_o, ar_done_o, r_done_o, w_done_o, b_done_o  out  1 each  channel handshake completed
- aw_len_o, ar_len_o  out  8  len of the completed AW/AR handshake
- aw_size_o, ar_size_o  out  3  size of the completed AW/AR handshake
- num_bytes_written_o  out  $clog2(StrbWidth)+1  bytes in the completed W beat
- dma_busy_o  out  1  any burst outstanding
- error_o  out  1  sticky counter overflow/underflow flag

Behaviour:
- Reset: all outputs 0, both outstanding counters 0, error flag 0.
- Latency: every event output reflects the AXI/buffer signals sampled in cycle t and appears at cycle t+1 (one register stage). No combinational path from inputs to outputs.
- Stall definition: X_stall = X_valid & ~X_ready.
- Done definition: X_done = X_valid & X_ready.
  - r_done pulses per beat; b_done pulses per response.
- aw_len_o/aw_size_o: load on aw handshake, otherwise 0. Same rule for ar_len_o/ar_size_o. The consumer multiplies only when done is high.
- num_bytes_written_o: popcount(w_strb_i) on w handshake, else 0. Range 0..StrbWidth.
- Write outstanding counter:
  - +1 on AW handshake, -1 on B handshake.
  - Both in the same cycle: no change.
- Read outstanding counter:
  - +1 on AR handshake, -1 on R handshake with r_last_i.
  - Both in the same cycle: no change.
- Overflow: increment alone with counter == MaxOutstanding → counter held, error flag set.
- Underflow: decrement alone with counter == 0 → counter held at 0, error flag set.
- error_o: sticky; cleared only by reset.
- dma_busy_o: registered; 1 in cycle t+1 iff either next-state counter is nonzero, or any of aw/ar/w valid was high in cycle t (a request is pending).
  - Goes 0 in the cycle after the last B and the last R-last complete with no new valid.
- Reset asserted mid-burst: counters and all outputs clear immediately (asynchronously). Post-reset responses on B/R with zero count are underflows and set error.

Optional Feature:
- Macro: SNITCH_DMA_EVENT_BYTE_ACCURATE_EN.
- Defined: num_bytes_written_o = popcount(w_strb_i) per W handshake, as described above.
- Undefined: popcount logic removed; num_bytes_written_o = StrbWidth on every W handshake, else 0. This saves area at the cost of overcounting partial-strobe beats.
- All other behaviour is identical in both builds.

Test Plan:
- AW valid held 3 cycles with ready low, then handshake with len=7, size=6 → aw_stall_o high for 3 cycles starting t+1; then one aw_done_o pulse with aw_len_o=7, aw_size_o=6; dma_busy_o stays 1 until the matching B.
- W beat with w_strb=0x00FF (DataWidth=512), then full strobe → num_bytes_written_o = 8, then 64 (64 for both without the macro).
- AR handshake (len=3) followed by 4 R beats, last on beat 4 → r_done_o pulses 4 times; dma_busy_o falls the cycle after the r_last beat is registered.
- Same-cycle AW handshake and B handshake with 1 write outstanding → counter stays 1, dma_busy_o stays 1, error_o stays 0.
- 17 AW handshakes with no B (MaxOutstanding=16) → error_o set on the 17th and stays set. Then a B with the counter at 0 after reset → error_o = 1 again.
- rst_ni pulsed low mid-burst with 2 reads outstanding → all outputs 0 in the same cycle; dma_busy_o = 0 after release with idle inputs.
